// File: rtl/interleaver_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : interleaver_bank_ctrl
// Brief    : Ping-pong bank sequencer for the block interleaver memory.
//            Fills one bank from the FEC while the other drains to the mapper.
// Revision : 1.0 - initial release
// ============================================================================
module interleaver_bank_ctrl #(
  parameter int NCBPS = 192,
  parameter int IDX_W = $clog2(NCBPS),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             ready_in,
  output logic             valid_out,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [IDX_W-1:0] wr_idx,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [IDX_W-1:0] rd_idx,
  output logic             block_done,
  output logic [CNT_W-1:0] block_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NCBPS - 1);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [1:0][1:0]   r_state;
  logic              r_wr_bank;
  logic [IDX_W-1:0]  r_wr_idx;
  logic              r_rd_bank;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_valid_out;
  logic              r_last;
  logic [CNT_W-1:0]  r_block_cnt;

  logic w_ready;
  logic w_wr_en;
  logic w_wr_last;
  logic w_rd_avail;
  logic w_rd_en;
  logic w_rd_last;
  logic w_deliver;

  assign w_ready    = (r_state[r_wr_bank] == S_EMPTY);
  assign w_wr_en    = valid_in & w_ready;
  assign w_wr_last  = w_wr_en & (r_wr_idx == c_last_idx);
  assign w_rd_avail = (r_state[r_rd_bank] == S_FULL) || (r_state[r_rd_bank] == S_DRAIN);
  // A new read is issued only when the output slot is free or being consumed.
  assign w_rd_en    = w_rd_avail & (~r_valid_out | ready_in);
  assign w_rd_last  = w_rd_en & (r_rd_idx == c_last_idx);
  assign w_deliver  = r_valid_out & ready_in;

  // Write and read banks are never the same bank in one cycle (EMPTY vs non-EMPTY),
  // so both state updates can apply on the same edge without conflict.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= {S_EMPTY, S_EMPTY};
      r_wr_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_idx    <= '0;
      r_valid_out <= 1'b0;
      r_last      <= 1'b0;
      r_block_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        if (w_wr_last) begin
          r_state[r_wr_bank] <= S_FULL;
          r_wr_bank          <= ~r_wr_bank;
          r_wr_idx           <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + c_idx_one;
        end
      end

      if (w_rd_en) begin
        r_last <= w_rd_last;
        if (w_rd_last) begin
          r_state[r_rd_bank] <= S_EMPTY;
          r_rd_bank          <= ~r_rd_bank;
          r_rd_idx           <= '0;
        end else begin
          r_state[r_rd_bank] <= S_DRAIN;
          r_rd_idx           <= r_rd_idx + c_idx_one;
        end
      end

      if (w_rd_en) begin
        r_valid_out <= 1'b1;
      end else if (ready_in) begin
        r_valid_out <= 1'b0;
      end

      if (w_deliver & r_last) begin
        r_block_cnt <= r_block_cnt + c_cnt_one;
      end
    end
  end

  assign ready_out  = w_ready;
  assign valid_out  = r_valid_out;
  assign wr_en      = w_wr_en;
  assign wr_bank    = r_wr_bank;
  assign wr_idx     = r_wr_idx;
  assign rd_en      = w_rd_en;
  assign rd_bank    = r_rd_bank;
  assign rd_idx     = r_rd_idx;
  assign block_done = w_deliver & r_last;
  assign block_cnt  = r_block_cnt;

endmodule
`default_nettype wire

// File: tb/tb_interleaver_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_interleaver_bank_ctrl
// Brief    : Directed scenario table plus a bank-memory scoreboard for
//            interleaver_bank_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interleaver_bank_ctrl;

  localparam int N     = 192;
  localparam int IDX_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetN;
  logic             valid_in;
  logic             ready_out;
  logic             ready_in;
  logic             valid_out;
  logic             wr_en;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_en;
  logic             rd_bank;
  logic [IDX_W-1:0] rd_idx;
  logic             block_done;
  logic [CNT_W-1:0] block_cnt;

  always #5 clk = ~clk;

  interleaver_bank_ctrl #(.NCBPS(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN),
    .valid_in(valid_in), .ready_out(ready_out),
    .ready_in(ready_in), .valid_out(valid_out),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_idx(rd_idx),
    .block_done(block_done), .block_cnt(block_cnt)
  );

  typedef struct {
    int vmode;      // 0: valid every cycle, 1: valid one cycle in three
    int rmode;      // 0: ready high, 1: ready low, 2: ready on even cycles
    int vlen;
    int ncyc;
    int exp_acc;
    int exp_del;
    int exp_cnt;
    int exp_done;
    int exp_first_vo;
    int exp_last_vo;
    int exp_vo_cycles;
    int exp_stall_in;
    int exp_ro;
    int exp_vo;
    int exp_rd_idx;
    int exp_rd_bank;
    int exp_wr_bank;
  } vec_t;

  vec_t vecs[5];

  int n_vec = 0;
  int n_bad = 0;

  int mem[2][N];
  int acc, rdc, del, rd_data, cyc;
  int first_vo, last_vo, vo_cycles, done_cnt, stall_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    acc = 0; rdc = 0; del = 0; rd_data = -1; cyc = 0;
    first_vo = -1; last_vo = -1; vo_cycles = 0; done_cnt = 0; stall_in = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready_out"},  32'(ready_out),  32'd1);
    chk({tag, "_valid_out"},  32'(valid_out),  32'd0);
    chk({tag, "_rd_en"},      32'(rd_en),      32'd0);
    chk({tag, "_block_done"}, 32'(block_done), 32'd0);
    chk({tag, "_block_cnt"},  32'(block_cnt),  32'd0);
    chk({tag, "_wr_idx"},     32'(wr_idx),     32'd0);
    chk({tag, "_rd_idx"},     32'(rd_idx),     32'd0);
    chk({tag, "_wr_bank"},    32'(wr_bank),    32'd0);
    chk({tag, "_rd_bank"},    32'(rd_bank),    32'd0);
  endtask

  task automatic apply_reset();
    resetN   = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    resetN = 1'b1;
    model_clear();
  endtask

  // Drives one cycle per iteration and scores every handshake against a bench-side bank memory.
  task automatic run_cycles(input int vmode, input int rmode, input int vlen, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      valid_in = (cyc < vlen) && (vmode == 0 || (cyc % 3) == 0);
      ready_in = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ((cyc % 2) == 0);
      #1;
      chk("wr_en_handshake", 32'(wr_en), 32'(valid_in & ready_out));
      if (valid_in && !ready_out) stall_in++;
      if (wr_en) begin
        chk("wr_idx", 32'(wr_idx), 32'(acc % N));
        chk("wr_bank", 32'(wr_bank), 32'((acc / N) % 2));
        if (int'(wr_idx) < N) mem[wr_bank][wr_idx] = acc;
        acc++;
      end
      if (valid_out) begin
        if (first_vo < 0) first_vo = cyc;
        last_vo = cyc;
        vo_cycles++;
      end
      if (block_done) done_cnt++;
      if (valid_out && !ready_in) chk("rd_en_during_stall", 32'(rd_en), 32'd0);
      if (valid_out && ready_in) begin
        chk("out_data_order", 32'(rd_data), 32'(del));
        chk("block_done_on_deliver", 32'(block_done), 32'((del % N) == N - 1));
        del++;
      end else begin
        chk("block_done_idle", 32'(block_done), 32'd0);
      end
      if (rd_en) begin
        chk("rd_idx", 32'(rd_idx), 32'(rdc % N));
        chk("rd_bank", 32'(rd_bank), 32'((rdc / N) % 2));
        chk("rd_from_full_bank", 32'(rdc < (acc / N) * N), 32'd1);
        rd_data = (int'(rd_idx) < N) ? mem[rd_bank][rd_idx] : -1;
        rdc++;
      end
      cyc++;
    end
  endtask

  initial begin
    // vmode rmode vlen ncyc | acc del cnt done first last vocyc stall | ro vo rdidx rdbank wrbank
    vecs[0] = '{0, 0, 192,  450, 192, 192, 1, 1, 193,  384, 192,   0, 1, 0, 0, 1, 1};
    vecs[1] = '{0, 0, 960, 1300, 960, 960, 5, 5, 193, 1152, 960,   0, 1, 0, 0, 1, 1};
    vecs[2] = '{0, 1, 600,  600, 384,   0, 0, 0, 193,  599, 407, 216, 0, 1, 1, 0, 0};
    vecs[3] = '{0, 2, 192,  800, 192, 192, 1, 1, 193,  576, 384,   0, 1, 0, 0, 1, 1};
    vecs[4] = '{1, 0, 576,  900, 192, 192, 1, 1, 575,  766, 192,   0, 1, 0, 0, 1, 1};

    for (int v = 0; v < 5; v++) begin
      apply_reset();
      run_cycles(vecs[v].vmode, vecs[v].rmode, vecs[v].vlen, vecs[v].ncyc);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_accepted", v),   32'(acc),        32'(vecs[v].exp_acc));
      chk($sformatf("v%0d_delivered", v),  32'(del),        32'(vecs[v].exp_del));
      chk($sformatf("v%0d_block_cnt", v),  32'(block_cnt),  32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_done_pulses", v),32'(done_cnt),   32'(vecs[v].exp_done));
      chk($sformatf("v%0d_first_vo", v),   32'(first_vo),   32'(vecs[v].exp_first_vo));
      chk($sformatf("v%0d_last_vo", v),    32'(last_vo),    32'(vecs[v].exp_last_vo));
      chk($sformatf("v%0d_vo_cycles", v),  32'(vo_cycles),  32'(vecs[v].exp_vo_cycles));
      chk($sformatf("v%0d_stall_in", v),   32'(stall_in),   32'(vecs[v].exp_stall_in));
      chk($sformatf("v%0d_ready_out", v),  32'(ready_out),  32'(vecs[v].exp_ro));
      chk($sformatf("v%0d_valid_out", v),  32'(valid_out),  32'(vecs[v].exp_vo));
      chk($sformatf("v%0d_rd_idx", v),     32'(rd_idx),     32'(vecs[v].exp_rd_idx));
      chk($sformatf("v%0d_rd_bank", v),    32'(rd_bank),    32'(vecs[v].exp_rd_bank));
      chk($sformatf("v%0d_wr_bank", v),    32'(wr_bank),    32'(vecs[v].exp_wr_bank));
    end

    // Asynchronous reset in the middle of the second block, away from any clock edge.
    apply_reset();
    run_cycles(0, 0, 1000, 292);
    @(negedge clk);
    #1;
    chk("mid_pre_wr_idx",    32'(wr_idx),    32'd100);
    chk("mid_pre_wr_bank",   32'(wr_bank),   32'd1);
    chk("mid_pre_rd_idx",    32'(rd_idx),    32'd100);
    chk("mid_pre_valid_out", 32'(valid_out), 32'd1);
    #1;
    resetN   = 1'b0;
    valid_in = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    model_clear();
    run_cycles(0, 0, 192, 450);
    @(negedge clk);
    #1;
    chk("post_reset_accepted",  32'(acc),       32'd192);
    chk("post_reset_delivered", 32'(del),       32'd192);
    chk("post_reset_first_vo",  32'(first_vo),  32'd193);
    chk("post_reset_block_cnt", 32'(block_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
